// File: rtl/risky_pkg.sv
// Shared widths and the response-slot state encoding for the operand fetch path.
package risky_pkg;
   localparam int REG_W      = 32;
   localparam int REG_ADDR_W = 5;
   localparam int TAG_W      = 8;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } fetch_state_t;
endpackage

// File: rtl/operand_bypass.sv
// One operand: records a same-edge writeback hit on the addressed register and
// selects bypass data, register-file data, or zero for x0 one clock later.
module operand_bypass
   import risky_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] rd_addr,
   input  logic [REG_ADDR_W-1:0] held_addr,
   input  logic                  wb_we,
   input  logic [REG_ADDR_W-1:0] wb_reg,
   input  logic [REG_W-1:0]      wb_data,
   input  logic [REG_W-1:0]      rf_data,
   output logic [REG_W-1:0]      val
);

   logic             hit_q;
   logic [REG_W-1:0] data_q;
   logic             hit_d;

   // The register file reads before it writes, so a write landing on the same
   // edge as the read is only visible through this recorded copy.
   assign hit_d = wb_we && (wb_reg != '0) && (wb_reg == rd_addr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_q  <= 1'b0;
         data_q <= '0;
      end else begin
         hit_q <= hit_d;
         if (hit_d) begin
            data_q <= wb_data;
         end
      end
   end

   assign val = (held_addr == '0) ? '0 : (hit_q ? data_q : rf_data);

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: single response slot, one-clock latency, one request per clock.
// req_ready = !rsp_valid || rsp_ready, held low during flush; response holds until rsp_ready.
module operand_fetch
   import risky_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [REG_ADDR_W-1:0] req_rs1,
   input  logic [REG_ADDR_W-1:0] req_rs2,
   input  logic [TAG_W-1:0]      req_tag,
   output logic [REG_ADDR_W-1:0] rf_reg_out_1,
   output logic [REG_ADDR_W-1:0] rf_reg_out_2,
   input  logic [REG_W-1:0]      rf_data_out_1,
   input  logic [REG_W-1:0]      rf_data_out_2,
   input  logic                  wb_we,
   input  logic [REG_ADDR_W-1:0] wb_reg,
   input  logic [REG_W-1:0]      wb_data,
   input  logic                  flush,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [REG_W-1:0]      rsp_rs1_val,
   output logic [REG_W-1:0]      rsp_rs2_val,
   output logic [TAG_W-1:0]      rsp_tag
);

   fetch_state_t          state_q, state_d;
   logic [REG_ADDR_W-1:0] rs1_q, rs2_q;
   logic [TAG_W-1:0]      tag_q;
   logic                  accept;

   assign rsp_valid = (state_q == FULL);
   assign req_ready = !flush && (!rsp_valid || rsp_ready);
   assign accept    = req_valid && req_ready;

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = EMPTY;
      end else if (accept) begin
         state_d = FULL;
      end else if ((state_q == FULL) && rsp_ready) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         rs1_q   <= '0;
         rs2_q   <= '0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            rs1_q <= req_rs1;
            rs2_q <= req_rs2;
            tag_q <= req_tag;
         end
      end
   end

   // While a response is held, keep re-reading its registers so that writes
   // committed during the hold show up on the following cycle.
   assign rf_reg_out_1 = accept ? req_rs1 : rs1_q;
   assign rf_reg_out_2 = accept ? req_rs2 : rs2_q;
   assign rsp_tag      = tag_q;

   operand_bypass u_byp_1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr   (rf_reg_out_1),
      .held_addr (rs1_q),
      .wb_we     (wb_we),
      .wb_reg    (wb_reg),
      .wb_data   (wb_data),
      .rf_data   (rf_data_out_1),
      .val       (rsp_rs1_val)
   );

   operand_bypass u_byp_2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr   (rf_reg_out_2),
      .held_addr (rs2_q),
      .wb_we     (wb_we),
      .wb_reg    (wb_reg),
      .wb_data   (wb_data),
      .rf_data   (rf_data_out_2),
      .val       (rsp_rs2_val)
   );

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vector table, reset/flush sequences, then
// randomized traffic against a transaction-level model and a behavioural register file.
module tb_operand_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready;
   logic [4:0]  req_rs1, req_rs2;
   logic [7:0]  req_tag;
   logic [4:0]  rf_reg_out_1, rf_reg_out_2;
   logic [31:0] rf_data_out_1, rf_data_out_2;
   logic        wb_we;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;
   logic        flush;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rs1_val, rsp_rs2_val;
   logic [7:0]  rsp_tag;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   operand_fetch dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_rs1       (req_rs1),
      .req_rs2       (req_rs2),
      .req_tag       (req_tag),
      .rf_reg_out_1  (rf_reg_out_1),
      .rf_reg_out_2  (rf_reg_out_2),
      .rf_data_out_1 (rf_data_out_1),
      .rf_data_out_2 (rf_data_out_2),
      .wb_we         (wb_we),
      .wb_reg        (wb_reg),
      .wb_data       (wb_data),
      .flush         (flush),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_rs1_val   (rsp_rs1_val),
      .rsp_rs2_val   (rsp_rs2_val),
      .rsp_tag       (rsp_tag)
   );

   // Register file: synchronous read of the pre-write contents; it even stores
   // writes to x0 so the DUT's zeroing of x0 is exercised.
   logic [31:0] mem [32];
   always @(posedge clk) begin
      rf_data_out_1 <= mem[rf_reg_out_1];
      rf_data_out_2 <= mem[rf_reg_out_2];
      if (wb_we) mem[wb_reg] <= wb_data;
   end

   function automatic logic [31:0] arch(input logic [4:0] r);
      return (r == 5'd0) ? 32'd0 : mem[r];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      else n_pass++;
   endtask

   typedef struct {
      logic        rv;
      logic [4:0]  rs1, rs2;
      logic [7:0]  tag;
      logic        rr, fl, we;
      logic [4:0]  wr;
      logic [31:0] wd;
      logic        e_rv, e_rdy;
      logic [7:0]  e_tag;
      logic [31:0] e_v1, e_v2;
   } vec_t;

   function automatic vec_t mk(input logic rv, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [7:0] tag, input logic rr, input logic fl,
                               input logic we, input logic [4:0] wr, input logic [31:0] wd,
                               input logic e_rv, input logic e_rdy, input logic [7:0] e_tag,
                               input logic [31:0] e_v1, input logic [31:0] e_v2);
      vec_t v;
      v.rv = rv; v.rs1 = rs1; v.rs2 = rs2; v.tag = tag; v.rr = rr; v.fl = fl;
      v.we = we; v.wr = wr; v.wd = wd; v.e_rv = e_rv; v.e_rdy = e_rdy;
      v.e_tag = e_tag; v.e_v1 = e_v1; v.e_v2 = e_v2;
      return v;
   endfunction

   vec_t tbl [25];

   logic       m_valid;
   logic [7:0] m_tag;
   logic [4:0] m_rs1, m_rs2;
   logic       e_rdy, acc;

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_tag = '0;
      rsp_ready = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_reg = '0; wb_data = '0;

      // Each row: inputs driven for one cycle, outputs expected in that same cycle.
      //            rv rs1 rs2 tag     rr fl we wr   wd            e_rv rdy e_tag  e_v1          e_v2
      tbl[0]  = mk(0, 0, 0, 8'h00,   1, 0, 1, 5, 32'h1234,     0, 1, 8'h00, 32'h0,       32'h0);
      tbl[1]  = mk(1, 5, 0, 8'h3A,   0, 0, 0, 0, 32'h0,        0, 1, 8'h00, 32'h0,       32'h0);
      tbl[2]  = mk(0, 0, 0, 8'h00,   1, 0, 0, 0, 32'h0,        1, 1, 8'h3A, 32'h1234,    32'h0);
      tbl[3]  = mk(0, 0, 0, 8'h00,   1, 0, 1, 7, 32'hAAAA,     0, 1, 8'h00, 32'h0,       32'h0);
      tbl[4]  = mk(1, 7, 5, 8'h11,   0, 0, 1, 7, 32'hCAFE,     0, 1, 8'h00, 32'h0,       32'h0);
      tbl[5]  = mk(0, 0, 0, 8'h00,   0, 0, 1, 7, 32'hBEEF,     1, 0, 8'h11, 32'hCAFE,    32'h1234);
      tbl[6]  = mk(0, 0, 0, 8'h00,   0, 0, 0, 0, 32'h0,        1, 0, 8'h11, 32'hBEEF,    32'h1234);
      tbl[7]  = mk(0, 0, 0, 8'h00,   1, 0, 0, 0, 32'h0,        1, 1, 8'h11, 32'hBEEF,    32'h1234);
      tbl[8]  = mk(0, 0, 0, 8'h00,   1, 0, 0, 0, 32'h0,        0, 1, 8'h00, 32'h0,       32'h0);
      tbl[9]  = mk(1, 5, 7, 8'h01,   1, 0, 0, 0, 32'h0,        0, 1, 8'h00, 32'h0,       32'h0);
      tbl[10] = mk(1, 5, 7, 8'h02,   1, 0, 0, 0, 32'h0,        1, 1, 8'h01, 32'h1234,    32'hBEEF);
      tbl[11] = mk(1, 5, 7, 8'h03,   1, 0, 0, 0, 32'h0,        1, 1, 8'h02, 32'h1234,    32'hBEEF);
      tbl[12] = mk(1, 5, 7, 8'h04,   1, 0, 0, 0, 32'h0,        1, 1, 8'h03, 32'h1234,    32'hBEEF);
      tbl[13] = mk(0, 0, 0, 8'h00,   1, 0, 0, 0, 32'h0,        1, 1, 8'h04, 32'h1234,    32'hBEEF);
      tbl[14] = mk(0, 0, 0, 8'h00,   1, 0, 0, 0, 32'h0,        0, 1, 8'h00, 32'h0,       32'h0);
      tbl[15] = mk(0, 0, 0, 8'h00,   1, 0, 1, 0, 32'hFFFF,     0, 1, 8'h00, 32'h0,       32'h0);
      tbl[16] = mk(1, 0, 0, 8'h55,   1, 0, 0, 0, 32'h0,        0, 1, 8'h00, 32'h0,       32'h0);
      tbl[17] = mk(0, 0, 0, 8'h00,   1, 0, 0, 0, 32'h0,        1, 1, 8'h55, 32'h0,       32'h0);
      tbl[18] = mk(1, 7, 7, 8'h66,   1, 0, 1, 7, 32'h7777,     0, 1, 8'h00, 32'h0,       32'h0);
      tbl[19] = mk(0, 0, 0, 8'h00,   1, 0, 0, 0, 32'h0,        1, 1, 8'h66, 32'h7777,    32'h7777);
      tbl[20] = mk(1, 5, 0, 8'h77,   0, 0, 0, 0, 32'h0,        0, 1, 8'h00, 32'h0,       32'h0);
      tbl[21] = mk(1, 5, 0, 8'h88,   0, 0, 0, 0, 32'h0,        1, 0, 8'h77, 32'h1234,    32'h0);
      tbl[22] = mk(1, 5, 0, 8'h88,   1, 1, 0, 0, 32'h0,        1, 0, 8'h77, 32'h1234,    32'h0);
      tbl[23] = mk(0, 0, 0, 8'h00,   0, 0, 0, 0, 32'h0,        0, 1, 8'h00, 32'h0,       32'h0);
      tbl[24] = mk(0, 0, 0, 8'h00,   1, 0, 0, 0, 32'h0,        0, 1, 8'h00, 32'h0,       32'h0);

      #1;
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_tag", 32'(rsp_tag), 32'd0);
      chk("reset_rs1_val", rsp_rs1_val, 32'd0);
      chk("reset_rs2_val", rsp_rs2_val, 32'd0);
      #16 rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 25; i++) begin
         req_valid = tbl[i].rv; req_rs1 = tbl[i].rs1; req_rs2 = tbl[i].rs2; req_tag = tbl[i].tag;
         rsp_ready = tbl[i].rr; flush = tbl[i].fl;
         wb_we = tbl[i].we; wb_reg = tbl[i].wr; wb_data = tbl[i].wd;
         @(negedge clk);
         chk($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].e_rv));
         chk($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].e_rdy));
         if (tbl[i].e_rv) begin
            chk($sformatf("vec%0d_tag", i), 32'(rsp_tag), 32'(tbl[i].e_tag));
            chk($sformatf("vec%0d_rs1_val", i), rsp_rs1_val, tbl[i].e_v1);
            chk($sformatf("vec%0d_rs2_val", i), rsp_rs2_val, tbl[i].e_v2);
         end
         @(posedge clk); #1;
      end

      // Reset asserted in the middle of a held response.
      req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd7; req_tag = 8'h99;
      rsp_ready = 1'b0; flush = 1'b0; wb_we = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("hold_before_reset_valid", 32'(rsp_valid), 32'd1);
      chk("hold_before_reset_tag", 32'(rsp_tag), 32'h99);
      #1 rst_n = 1'b0;
      #1;
      chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midreset_rsp_tag", 32'(rsp_tag), 32'd0);
      chk("midreset_rs1_val", rsp_rs1_val, 32'd0);
      chk("midreset_rs2_val", rsp_rs2_val, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b1; req_rs1 = 5'd7; req_rs2 = 5'd0; req_tag = 8'hA5; rsp_ready = 1'b1;
      @(negedge clk);
      chk("post_reset_req_ready", 32'(req_ready), 32'd1);
      chk("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("post_reset_valid", 32'(rsp_valid), 32'd1);
      chk("post_reset_tag", 32'(rsp_tag), 32'hA5);
      chk("post_reset_rs1_val", rsp_rs1_val, 32'h7777);
      chk("post_reset_rs2_val", rsp_rs2_val, 32'd0);
      @(posedge clk); #1;

      // Randomized traffic against the transaction-level model.
      m_valid = 1'b0; m_tag = 8'hA5; m_rs1 = 5'd7; m_rs2 = 5'd0;
      for (int c = 0; c < 600; c++) begin
         req_valid = ($urandom_range(0, 3) != 0);
         req_rs1   = 5'($urandom_range(0, 7));
         req_rs2   = 5'($urandom_range(0, 7));
         req_tag   = 8'($urandom_range(0, 255));
         rsp_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         wb_we     = ($urandom_range(0, 1) != 0);
         wb_reg    = 5'($urandom_range(0, 7));
         wb_data   = $urandom;
         @(negedge clk);
         e_rdy = !flush && (!m_valid || rsp_ready);
         acc   = req_valid && e_rdy;
         chk("rnd_req_ready", 32'(req_ready), 32'(e_rdy));
         chk("rnd_rsp_valid", 32'(rsp_valid), 32'(m_valid));
         if (m_valid) begin
            chk("rnd_tag", 32'(rsp_tag), 32'(m_tag));
            chk("rnd_rs1_val", rsp_rs1_val, arch(m_rs1));
            chk("rnd_rs2_val", rsp_rs2_val, arch(m_rs2));
         end
         if (acc || m_valid) begin
            chk("rnd_rf_addr1", 32'(rf_reg_out_1), 32'(acc ? req_rs1 : m_rs1));
            chk("rnd_rf_addr2", 32'(rf_reg_out_2), 32'(acc ? req_rs2 : m_rs2));
         end
         @(posedge clk);
         if (flush) begin
            m_valid = 1'b0;
         end else if (acc) begin
            m_valid = 1'b1; m_tag = req_tag; m_rs1 = req_rs1; m_rs2 = req_rs2;
         end else if (rsp_ready) begin
            m_valid = 1'b0;
         end
         #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
